// File: rtl/snode_k.sv
// snode_k: clause-storage node of the SAT propagation chain with a QDEPTH output FIFO.
// Build macro SNODE_DUP_SUPPRESS_EN: when defined, an ADD duplicating an occupied slot is consumed.

package pkg;
  typedef enum logic [2:0] {
    DEL = 3'd0,
    ADD = 3'd1,
    SET = 3'd2,
    RDC = 3'd3,
    MSC = 3'd4
  } opcode;
endpackage

module snode_k
  import pkg::*;
#(
  parameter int LITS   = 3,
  parameter int IDW    = 28,
  parameter int QDEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bgn_in,
  output logic           fns_out,
  input  opcode          opc_in,
  input  logic           mode_in,
  input  logic [IDW-1:0] id_in,
  output logic           bgn_out,
  input  logic           fns_in,
  output opcode          opc_out,
  output logic           mode_out,
  output logic [IDW-1:0] id_out
);

  typedef struct packed {
    opcode          opc;
    logic           mode;
    logic [IDW-1:0] id;
  } msg_t;

  typedef enum logic [1:0] {UP_EMPTY, UP_HEAD, UP_UNIT, UP_MULTI} up_t;

  localparam int CW = $clog2(QDEPTH + 1);

  logic [IDW-1:0]  cla, cla_n;
  up_t             up, up_n;
  logic [LITS-1:0] sign, sign_n, live, live_n, vacant, fals;
  logic [IDW-1:0]  lit_abs   [LITS];
  logic [IDW-1:0]  lit_abs_n [LITS];
  msg_t            q [QDEPTH];
  logic [CW-1:0]   count;
  msg_t            push0, push1;
  logic [1:0]      npush;
  logic            accept, pop, found, dup;
  logic [3:0]      cnt, t;

  // free>=2 guarantees room for a forward plus a generated RDC.
  assign accept = bgn_in && !fns_out && (count <= CW'(QDEPTH - 2));
  assign pop    = fns_in && bgn_out;
  assign cnt    = 4'($countones(live));

  assign bgn_out  = (count != '0);
  assign opc_out  = bgn_out ? q[0].opc  : DEL;
  assign mode_out = bgn_out ? q[0].mode : 1'b0;
  assign id_out   = bgn_out ? q[0].id   : '0;

  always_comb begin
    for (int i = 0; i < LITS; i++) begin
      vacant[i] = (lit_abs[i] == '0) && !sign[i];
      fals[i]   = live[i] && (sign[i] != mode_in) && (lit_abs[i] == id_in);
    end
  end

`ifdef SNODE_DUP_SUPPRESS_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < LITS; i++)
      if (!vacant[i] && lit_abs[i] == id_in && sign[i] == mode_in) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    cla_n     = cla;
    up_n      = up;
    sign_n    = sign;
    live_n    = live;
    lit_abs_n = lit_abs;
    push0     = '{opc: opc_in, mode: mode_in, id: id_in};
    push1     = '{opc: RDC, mode: 1'b0, id: cla};
    npush     = 2'd1;
    found     = 1'b0;
    t         = '0;
    case (opc_in)
      DEL: begin
        if (id_in == cla) begin
          cla_n  = '0;
          up_n   = UP_EMPTY;
          sign_n = '0;
          live_n = '0;
          for (int i = 0; i < LITS; i++) lit_abs_n[i] = '0;
        end
      end
      SET: begin
        live_n = live & ~fals;
        if (|fals && up != UP_MULTI) begin
          t = 4'($countones(live_n)) + {3'b000, up == UP_UNIT};
          if (t <= 4'd1) begin
            push1.mode = (t == 4'd1);
            npush      = 2'd2;
          end
        end
      end
      ADD: begin
        if (cla == '0) begin
          cla_n = id_in;
          up_n  = mode_in ? UP_HEAD : UP_MULTI;
          npush = 2'd0;
        end else if (dup) begin
          npush = 2'd0;
        end else begin
          for (int i = 0; i < LITS; i++) begin
            if (vacant[i] && !found) begin
              found        = 1'b1;
              sign_n[i]    = mode_in;
              lit_abs_n[i] = id_in;
              live_n[i]    = 1'b1;
            end
          end
          if (found) npush = 2'd0;
        end
      end
      RDC: begin
        if (id_in == cla) begin
          push0 = '{opc: RDC, mode: 1'b1, id: cla};
          if (!mode_in) begin
            up_n       = UP_EMPTY;
            push0.mode = (cnt == 4'd1);
            npush      = (cnt <= 4'd1) ? 2'd1 : 2'd0;
          end else begin
            up_n  = UP_UNIT;
            npush = (cnt == 4'd0) ? 2'd1 : 2'd0;
          end
        end
      end
      MSC: begin
        if (id_in == IDW'(1)) begin
          if (up != UP_HEAD) up_n = UP_MULTI;
          for (int i = 0; i < LITS; i++) live_n[i] = (lit_abs[i] != '0);
        end else if (id_in == '0 && |vacant) begin
          sign_n = sign | vacant;
          npush  = 2'd0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fns_out <= 1'b0;
      count   <= '0;
      cla     <= '0;
      up      <= UP_EMPTY;
      sign    <= '0;
      live    <= '0;
      for (int i = 0; i < LITS; i++) lit_abs[i] <= '0;
    end else begin
      fns_out <= accept;
      count   <= count + (accept ? CW'(npush) : CW'(0)) - CW'(pop);
      if (accept) begin
        cla     <= cla_n;
        up      <= up_n;
        sign    <= sign_n;
        live    <= live_n;
        lit_abs <= lit_abs_n;
      end
    end
  end

  // NOTE: FIFO storage is not reset; count alone decides validity and gates the outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH - 1; i++)
      if (pop) q[i] <= q[i + 1];
    for (int i = 0; i < QDEPTH; i++) begin
      if (accept && npush != 2'd0 && i == int'(count) - int'(pop)) q[i] <= push0;
      if (accept && npush == 2'd2 && i == int'(count) - int'(pop) + 1) q[i] <= push1;
    end
  end

endmodule

// File: tb/tb_snode_k.sv
// Self-checking bench for snode_k: a message-level clause model predicts the output stream,
// a per-cycle compare process checks the queue head, and directed phases pin literal results.

module tb_snode_k;
  import pkg::*;

  localparam int LITS   = 3;
  localparam int IDW    = 28;
  localparam int QDEPTH = 2;
  localparam int EMPTY = 0, HEAD = 1, UNIT = 2, MULTI = 3;

  logic           clk = 1'b0;
  logic           rst, bgn_in, fns_out, mode_in, bgn_out, fns_in, mode_out;
  opcode          opc_in, opc_out;
  logic [IDW-1:0] id_in, id_out;

  snode_k #(.LITS(LITS), .IDW(IDW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .bgn_in(bgn_in), .fns_out(fns_out), .opc_in(opc_in),
    .mode_in(mode_in), .id_in(id_in), .bgn_out(bgn_out), .fns_in(fns_in),
    .opc_out(opc_out), .mode_out(mode_out), .id_out(id_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int opc;
    int mode;
    int id;
  } msg_t;

  msg_t exp_q[$];
  msg_t log_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Clause model: literals live in numbered slots; a slot with value 0 and sign 0 is vacant.
  int m_cla, m_up;
  int m_sign [LITS];
  int m_abs  [LITS];
  int m_live [LITS];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cla = 0;
    m_up  = EMPTY;
    for (int i = 0; i < LITS; i++) begin
      m_sign[i] = 0;
      m_abs[i]  = 0;
      m_live[i] = 0;
    end
  endfunction

  function automatic int live_lits();
    int n = 0;
    for (int i = 0; i < LITS; i++) n += m_live[i];
    return n;
  endfunction

  function automatic bit is_vacant(int i);
    return m_abs[i] == 0 && m_sign[i] == 0;
  endfunction

  function automatic void model_apply(int op, int mode, int id);
    bit fwd = 1;
    if (op == int'(DEL)) begin
      if (id == m_cla) model_reset();
    end else if (op == int'(SET)) begin
      bit hit = 0;
      for (int i = 0; i < LITS; i++)
        if (m_live[i] == 1 && m_sign[i] != mode && m_abs[i] == id) begin
          m_live[i] = 0;
          hit = 1;
        end
      exp_q.push_back('{op, mode, id});
      fwd = 0;
      if (hit && m_up != MULTI) begin
        int remaining = live_lits() + (m_up == UNIT ? 1 : 0);
        if (remaining == 1) exp_q.push_back('{int'(RDC), 1, m_cla});
        if (remaining == 0) exp_q.push_back('{int'(RDC), 0, m_cla});
      end
    end else if (op == int'(ADD)) begin
      if (m_cla == 0) begin
        m_cla = id;
        m_up  = mode ? HEAD : MULTI;
        fwd   = 0;
      end else begin
        bit dup = 0;
`ifdef SNODE_DUP_SUPPRESS_EN
        for (int i = 0; i < LITS; i++)
          if (!is_vacant(i) && m_abs[i] == id && m_sign[i] == mode) dup = 1;
`endif
        if (dup) fwd = 0;
        for (int i = 0; i < LITS && fwd; i++)
          if (is_vacant(i)) begin
            m_sign[i] = mode;
            m_abs[i]  = id;
            m_live[i] = 1;
            fwd = 0;
          end
      end
    end else if (op == int'(RDC)) begin
      if (id == m_cla) begin
        int c = live_lits();
        fwd = 0;
        if (mode == 0) begin
          m_up = EMPTY;
          if (c == 1) exp_q.push_back('{int'(RDC), 1, m_cla});
          if (c == 0) exp_q.push_back('{int'(RDC), 0, m_cla});
        end else begin
          m_up = UNIT;
          if (c == 0) exp_q.push_back('{int'(RDC), 1, m_cla});
        end
      end
    end else if (op == int'(MSC)) begin
      if (id == 1) begin
        if (m_up != HEAD) m_up = MULTI;
        for (int i = 0; i < LITS; i++) m_live[i] = (m_abs[i] != 0) ? 1 : 0;
      end else if (id == 0) begin
        for (int i = 0; i < LITS; i++)
          if (is_vacant(i)) begin
            m_sign[i] = 1;
            fwd = 0;
          end
      end
    end
    if (fwd) exp_q.push_back('{op, mode, id});
  endfunction

  // Model pop mirrors the downstream acknowledge on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (fns_in && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // Per-cycle compare of the queue head against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) begin
        check("head_valid", int'(bgn_out), 1);
        check("head_opc",   int'(opc_out), exp_q[0].opc);
        check("head_mode",  int'(mode_out), exp_q[0].mode);
        check("head_id",    int'(id_out), exp_q[0].id);
      end else begin
        check("idle_valid", int'(bgn_out), 0);
        check("idle_opc",   int'(opc_out), int'(DEL));
        check("idle_mode",  int'(mode_out), 0);
        check("idle_id",    int'(id_out), 0);
      end
      if (bgn_out && fns_in) log_q.push_back('{int'(opc_out), int'(mode_out), int'(id_out)});
    end
  end

  task automatic do_reset();
    rst    = 1'b1;
    bgn_in = 1'b0;
    fns_in = 1'b1;
    opc_in = DEL;
    mode_in = 1'b0;
    id_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
  endtask

  task automatic send(opcode op, int mode, int id);
    bit got = 0;
    bgn_in  = 1'b1;
    opc_in  = op;
    mode_in = mode[0];
    id_in   = IDW'(id);
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (fns_out) got = 1;
    end
    check("accept_in_time", int'(got), 1);
    if (got) model_apply(int'(op), mode, id);
    bgn_in = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_log(string name, opcode opc, int mode, int id);
    msg_t m;
    if (log_q.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      m = log_q.pop_front();
      check({name, "_opc"}, m.opc, int'(opc));
      check({name, "_mode"}, m.mode, mode);
      check({name, "_id"}, m.id, id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    do_reset();
    @(negedge clk);
    check("rst_fns_out", int'(fns_out), 0);
    check("rst_bgn_out", int'(bgn_out), 0);
    check("rst_opc_out", int'(opc_out), int'(DEL));
    check("rst_id_out",  int'(id_out), 0);
    @(posedge clk);
    #1;

    // Load and overflow
    send(ADD, 1, 5);
    send(ADD, 1, 10);
    send(ADD, 0, 11);
    send(ADD, 1, 12);
    idle(3);
    check("load_consumed", log_q.size(), 0);
    check("model_cla", m_cla, 5);
    check("model_up_head", m_up, HEAD);
    send(ADD, 1, 13);
    idle(3);
    expect_log("overflow_fwd", ADD, 1, 13);

    // Unit reduction
    send(MSC, 0, 1);
    send(SET, 0, 10);
    idle(3);
    expect_log("unf_fwd", MSC, 0, 1);
    expect_log("set10", SET, 0, 10);
    check("set10_no_rdc", log_q.size(), 0);
    send(SET, 1, 11);
    idle(4);
    expect_log("set11", SET, 1, 11);
    expect_log("rdc_unit", RDC, 1, 5);

    // Empty reduction, then DEL clears the node
    send(SET, 0, 12);
    idle(4);
    expect_log("set12", SET, 0, 12);
    expect_log("rdc_empty", RDC, 0, 5);
    send(DEL, 0, 5);
    send(ADD, 1, 7);
    idle(3);
    expect_log("del_fwd", DEL, 0, 5);
    check("del_cleared_add_consumed", log_q.size(), 0);

    // Chain reduction on cla=7 with no live slots
    send(RDC, 1, 7);
    idle(3);
    expect_log("chain_rdc1", RDC, 1, 7);
    check("model_up_unit", m_up, UNIT);
    send(RDC, 0, 7);
    send(RDC, 1, 99);
    idle(4);
    expect_log("chain_rdc0", RDC, 0, 7);
    expect_log("foreign_rdc_fwd", RDC, 1, 99);

    // FLL marks all vacant slots, so later ADDs find no room
    send(MSC, 0, 0);
    send(ADD, 0, 20);
    idle(3);
    expect_log("fll_then_add_fwd", ADD, 0, 20);

    // Backpressure with a stalled downstream, ending in a reset mid-transfer
    do_reset();
    fns_in = 1'b0;
    send(MSC, 0, 5);
    bgn_in  = 1'b1;
    opc_in  = DEL;
    mode_in = 1'b0;
    id_in   = IDW'(3);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("bp_hold_fns", int'(fns_out), 0);
    end
    fns_in = 1'b1;
    @(posedge clk);
    #1;
    fns_in = 1'b0;
    check("bp_pop_edge_fns", int'(fns_out), 0);
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(posedge clk);
      #1;
      if (fns_out) got = 1;
    end
    check("bp_accept_after_pop", int'(got), 1);
    if (got) model_apply(int'(DEL), 0, 3);
    bgn_in = 1'b0;
    idle(2);
    expect_log("bp_first", MSC, 0, 5);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_fns_out", int'(fns_out), 0);
    check("midrst_bgn_out", int'(bgn_out), 0);
    rst = 1'b0;
    fns_in = 1'b1;
    log_q.delete();

    // Duplicate ADD handling
    do_reset();
    send(ADD, 1, 5);
    send(ADD, 1, 9);
    send(ADD, 1, 9);
    send(ADD, 1, 30);
    send(ADD, 1, 31);
    send(ADD, 1, 32);
    idle(4);
`ifdef SNODE_DUP_SUPPRESS_EN
    expect_log("dup_full_fwd", ADD, 1, 32);
`else
    expect_log("dup_overflow_fwd", ADD, 1, 31);
    expect_log("dup_full_fwd", ADD, 1, 32);
`endif
    check("dup_log_drained", log_q.size(), 0);

    idle(3);
    check("final_model_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
